// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The optional trailer-byte checksum is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int IDX_W      = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        CHECK = 3'd4
    } state_t;

    function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] a,
                                                   input logic [BYTE_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if #(
    parameter int AW = 32
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wea;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, wea, waddr, wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, wea, waddr, wdata
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler; word presents the merged value including the byte
// being accepted this cycle, and word_full flags acceptance of the last byte of a word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              take,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [31:0]       word,
    output logic              word_full
);

    logic [IDX_W-1:0] idx;
    logic [31:0]      acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            acc <= '0;
        end else if (clr) begin
            idx <= '0;
            acc <= '0;
        end else if (take) begin
            acc[{idx, 3'b000} +: BYTE_W] <= byte_in;
            idx                          <= idx + IDX_W'(1);
        end
    end

    always_comb begin
        word = acc;
        if (take) word[{idx, 3'b000} +: BYTE_W] = byte_in;
    end

    assign word_full = take && (idx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into the instruction memory one packed word at a time while stalling the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] word_cnt,
    input  logic [AW-1:0]    base_addr,
    input  logic             abort,
    imem_loader_if.master    bus,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state, state_nxt;
    logic [AW-1:0]    addr, waddr_r;
    logic [CNT_W-1:0] remaining;
    logic [31:0]      wdata_r, pk_word;
    logic             start_ok, take, pk_clr, word_full;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        return (a >= AW'(DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    assign start_ok = start && (state == IDLE || state == DONE);
    assign take     = bus.rx_valid && (state == LOAD);
    assign pk_clr   = start_ok || (abort && (state == LOAD || state == WRITE));

    byte_packer u_packer (
        .clk       (clka),
        .rst_n     (rst_n),
        .clr       (pk_clr),
        .take      (take),
        .byte_in   (bus.rx_data),
        .word      (pk_word),
        .word_full (word_full)
    );

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.rx_ready = 1'b0;
        bus.wea      = 1'b0;
        busy         = 1'b0;
        cpu_hold     = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) state_nxt = (word_cnt == '0) ? DONE : LOAD;
            end
            LOAD: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                cpu_hold     = 1'b1;
                if (abort)          state_nxt = IDLE;
                else if (word_full) state_nxt = WRITE;
            end
            WRITE: begin
                bus.wea  = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (abort) state_nxt = IDLE;
                else if (remaining == CNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = CHECK;
`else
                    state_nxt = DONE;
`endif
                end else state_nxt = LOAD;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                bus.rx_ready = 1'b1;
                cpu_hold     = 1'b1;
                if (bus.rx_valid) state_nxt = DONE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Write-port registers capture on the 4th byte so they hold steady between writes
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            waddr_r   <= '0;
            wdata_r   <= '0;
        end else begin
            if (start_ok) begin
                addr      <= base_addr;
                remaining <= word_cnt;
            end else if (state == WRITE) begin
                addr      <= wrap_inc(addr);
                remaining <= remaining - CNT_W'(1);
            end
            if (state == LOAD && word_full && !abort) begin
                waddr_r <= addr;
                wdata_r <= pk_word;
            end
        end
    end

    assign bus.waddr = waddr_r;
    assign bus.wdata = wdata_r;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum;
    logic              err_r;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            err_r <= 1'b0;
        end else if (start_ok) begin
            sum   <= '0;
            err_r <= 1'b0;
        end else begin
            if (take) sum <= csum_add(sum, bus.rx_data);
            if (state == CHECK && bus.rx_valid)
                err_r <= (csum_add(sum, bus.rx_data) != 8'd0);
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the CPU's instruction memory, which the core only reads.
- Accepts a byte stream (UART/debug bridge) after a start command and packs bytes little-endian into 32-bit words.
- Issues one word write per word into the instruction memory write port at consecutive word addresses.
- Holds the CPU in stall while loading and reports done/error.

Parameters:
- DEPTH, 1024, instruction memory depth in words; write addresses wrap modulo DEPTH.
- AW, 32, width of the write word-address port; matches the memory's 32-bit word index.
- CNT_W, 16, width of the word-count command field.

Ports:
- clka  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle command pulse; sampled only in IDLE or DONE.
- word_cnt  input  CNT_W  number of words to load; sampled with start.
- base_addr  input  AW  first word index; sampled with start.
- abort  input  1  cancels a load in progress.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  byte valid.
- rx_ready  output  1  loader accepts a byte; a byte transfers when valid&ready.
- wea  output  1  instruction memory write strobe, one cycle per word.
- waddr  output  AW  word index for the write.
- wdata  output  32  packed word.
- cpu_hold  output  1  stalls the core / forces its fetch enable low.
- busy  output  1  high in LOAD/WRITE.
- done  output  1  sticky completion flag, cleared by the next start.
- err  output  1  sticky error flag, cleared by the next start; only driven when the optional feature is compiled in.

Behaviour:
- Reset (async, rst_n=0): state IDLE. Outputs rx_ready=0, wea=0, waddr=0, wdata=0, cpu_hold=0, busy=0, done=0, err=0. Byte index=0, word counter=0.
- State IDLE / DONE:
  - start=1 latches word_cnt, base_addr; clears done and err; next state LOAD.
  - If word_cnt=0, go to DONE instead; done=1 next cycle and no writes occur.
- State LOAD:
  - rx_ready=1, busy=1, cpu_hold=1.
  - Each accepted byte k (0..3) is placed at wdata[8k+7:8k].
  - On acceptance of byte 3, next state is WRITE.
- State WRITE (exactly one cycle):
  - wea=1; waddr=current address; wdata=packed word; rx_ready=0.
  - Address increments modulo DEPTH, so wrap goes DEPTH-1 to 0.
  - Remaining count decrements. If it reaches 0, next state is DONE (or CHECK with the feature); otherwise back to LOAD.
- Write timing: wea is asserted on the cycle after the 4th byte handshake. Peak throughput is 4 bytes per 5 cycles.
- State DONE: done=1, cpu_hold=0, busy=0, rx_ready=0. A new start is accepted.
- abort=1 in LOAD or WRITE:
  - Next state IDLE; partial word discarded; done stays 0.
  - A WRITE in the same cycle as abort still completes (wea=1 that cycle).
  - abort is ignored in IDLE/DONE.
- start during LOAD or WRITE is ignored.
- cpu_hold deasserts on the same edge busy falls.
- wdata/waddr hold their last values when wea=0.
- Reset mid-load returns everything to reset values immediately; the memory contents already written are kept.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - An 8-bit running sum (mod 256) covers all payload bytes.
  - After the last WRITE the FSM enters CHECK: rx_ready=1, one more byte is accepted, then DONE.
  - err=1 if that byte differs from the two's-complement of the sum, i.e. (sum+byte) mod 256 must be 0.
  - cpu_hold stays high through CHECK.
- When undefined: no CHECK state, and err is tied to 0.

Decomposition:
- Package imem_loader_pkg:
  - state encoding constants IDLE=0, LOAD=1, WRITE=2, DONE=3, CHECK=4 (3-bit).
  - BYTE_W=8, WORD_BYTES=4.
- One natural sub-module, byte_packer: byte index counter plus 32-bit shift/assemble register, outputs word_full. The FSM, counters and checksum stay in the top module.

Test Plan:
- Load 2 words from base 0: bytes 13,07,40,00,93,06,40,00 -> wea pulses twice, waddr 0 then 1, wdata 0x00400713 then 0x00400693; done=1, cpu_hold low after the second write.
- Backpressure: rx_valid toggled at random with the same stream -> identical writes; rx_ready low during each WRITE cycle.
- Wrap: base_addr=1023, word_cnt=2 -> waddr 1023 then 0.
- Abort after 6 bytes of a 3-word load -> exactly one write (waddr=base), state IDLE, done=0, cpu_hold=0.
- word_cnt=0 with start -> no wea, done=1 after one cycle; start while busy -> ignored, load continues unchanged.
- Checksum (with IMEM_LOADER_CHECKSUM_EN): payload 13,07,40,00 (sum 0x5A), trailer 0xA6 -> err=0; trailer 0xA5 -> err=1; done=1 in both cases.
